serial_adder_stage: RTL

- Bit-serial add stage directly downstream of the ALU operand preprocessor.
- Consumes the already-modified operands AMod and BMod and produces their sum, LSB first, one bit per clock.
- Also produces the carry, zero, negative and overflow flags.
- Uses a start/ready/done handshake, so the ALU controller can launch an operation and wait for completion.

---
 rtl/serial_adder_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder_stage.sv
// -----------------------------------------------------------------------------
// serial_adder_stage
//
// Bit-serial adder sitting behind the ALU operand preprocessor. A launch in
// IDLE captures AMod/BMod/Cin; the sum is then built LSB first, one bit per
// clock, over WIDTH RUN cycles. The final sum and the C/Z/N/V flags are loaded
// into output registers on the last RUN edge, and done pulses for the single
// DONE cycle that follows.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   synchronous active-high reset
//   start  in   launch request, honoured only while ready=1
//   AMod   in   first operand  [WIDTH-1:0]
//   BMod   in   second operand [WIDTH-1:0]
//   Cin    in   carry into bit 0
//   ready  out  high in IDLE
//   done   out  one-cycle pulse, result registers just updated
//   S      out  AMod+BMod+Cin mod 2^WIDTH
//   Cout   out  carry out of the MSB
//   Z      out  S == 0
//   N      out  S[WIDTH-1]
//   V      out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] AMod,
    input  logic [WIDTH-1:0] BMod,
    input  logic             Cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    // One-bit full adder on the operand LSBs and the running carry.
    logic fa_sum;
    logic fa_carry;

    always_comb begin
        fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
        fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = AMod;
                    b_d     = BMod;
                    carry_d = Cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the MSB edge carry_q is the carry into the MSB, so V
                    // is formed here directly against the MSB carry out.
                    state_d = DONE;
                    s_d     = sum_d;
                    cout_d  = fa_carry;
                    z_d     = (sum_d == '0);
                    n_d     = fa_sum;
                    v_d     = carry_q ^ fa_carry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
        S     = s_q;
        Cout  = cout_q;
        Z     = z_q;
        N     = n_q;
        V     = v_q;
    end

endmodule
